// File: rtl/priority_resolver_n.sv
// Purpose : N-channel interrupt priority resolver with masking, full nesting and rotating priority.
// Latency : int_req one cycle after an eligible request appears; vector/isr update on the inta edge.
// Backpres: none; requests are level-held by the source and wait in irr until acknowledged.
//
// Ports: clk/rst (async active-high); irr/imr request and mask levels; rotate_en, sp_rot/sp_level
// control the lowest-priority pointer; eoi/eoi_specific/eoi_level end service; inta acknowledges.
// Outputs: int_req, int_vec, vec_valid, spurious (registered) and isr (in-service register).
module priority_resolver_n #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] irr,
    input  logic [N-1:0] imr,
    input  logic         rotate_en,
    input  logic         sp_rot,
    input  logic [W-1:0] sp_level,
    input  logic         eoi,
    input  logic         eoi_specific,
    input  logic [W-1:0] eoi_level,
    input  logic         inta,
    output logic         int_req,
    output logic [W-1:0] int_vec,
    output logic         vec_valid,
    output logic         spurious,
    output logic [N-1:0] isr
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   lp_q, lp_d;
    logic [N-1:0]   isr_q, isr_d;
    logic [W-1:0]   int_vec_q, int_vec_d;
    logic           vec_valid_q, vec_valid_d;
    logic           spurious_q, spurious_d;

    logic [N-1:0]   cand;
    logic           win_found;
    logic [W-1:0]   win_idx;
    logic [W-1:0]   win_rank;
    logic           isr_found;
    logic [W-1:0]   isr_idx;
    logic [W-1:0]   isr_rank;
    logic           eligible;
    logic           clr_vld;
    logic [W-1:0]   clr_idx;
    logic [N-1:0]   clr_mask;
    logic [N-1:0]   set_mask;

    // Priority search: walk offsets 1..N from lp. Because N is a power of two the W-bit
    // index wraps naturally, and the loop offset doubles as the priority rank (0 = highest).
    always_comb begin
        cand      = irr & ~imr & ~isr_q;
        win_found = 1'b0;
        win_idx   = '0;
        win_rank  = '0;
        isr_found = 1'b0;
        isr_idx   = '0;
        isr_rank  = '0;
        for (int k = 0; k < N; k++) begin
            if (!win_found && cand[lp_q + W'(k + 1)]) begin
                win_found = 1'b1;
                win_idx   = lp_q + W'(k + 1);
                win_rank  = W'(k);
            end
            if (!isr_found && isr_q[lp_q + W'(k + 1)]) begin
                isr_found = 1'b1;
                isr_idx   = lp_q + W'(k + 1);
                isr_rank  = W'(k);
            end
        end
        // Full nesting: a new winner must strictly outrank everything already in service.
        eligible = win_found && (!isr_found || (win_rank < isr_rank));
    end

    // EOI clear and acknowledge set, both from pre-edge state; set is OR'd last so it wins.
    always_comb begin
        clr_vld  = 1'b0;
        clr_idx  = '0;
        clr_mask = '0;
        set_mask = '0;
        if (eoi) begin
            if (eoi_specific) begin
                clr_idx = eoi_level;
                clr_vld = isr_q[eoi_level];
            end else begin
                clr_idx = isr_idx;
                clr_vld = isr_found;
            end
        end
        if (clr_vld) begin
            clr_mask = N'(1) << clr_idx;
        end
        if (inta && eligible) begin
            set_mask = N'(1) << win_idx;
        end
        isr_d = (isr_q & ~clr_mask) | set_mask;
    end

    // Rotation only follows an EOI that actually retired a bit; an explicit sp_rot overrides it.
    always_comb begin
        lp_d = lp_q;
        if (sp_rot) begin
            lp_d = sp_level;
        end else if (rotate_en && clr_vld) begin
            lp_d = clr_idx;
        end
    end

    // Acknowledge handling and request FSM. Every inta returns to IDLE; without inta the
    // request is simply re-evaluated each cycle, so a withdrawn request drops int_req.
    always_comb begin
        state_d     = state_q;
        int_vec_d   = int_vec_q;
        vec_valid_d = 1'b0;
        spurious_d  = 1'b0;
        if (inta) begin
            state_d     = ST_IDLE;
            vec_valid_d = 1'b1;
            if (eligible) begin
                int_vec_d = win_idx;
            end else begin
                int_vec_d  = W'(N - 1);
                spurious_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = eligible ? ST_REQ : ST_IDLE;
                ST_REQ:  state_d = eligible ? ST_REQ : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lp_q        <= W'(N - 1);
            isr_q       <= '0;
            int_vec_q   <= '0;
            vec_valid_q <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lp_q        <= lp_d;
            isr_q       <= isr_d;
            int_vec_q   <= int_vec_d;
            vec_valid_q <= vec_valid_d;
            spurious_q  <= spurious_d;
        end
    end

    assign int_req   = (state_q == ST_REQ);
    assign int_vec   = int_vec_q;
    assign vec_valid = vec_valid_q;
    assign spurious  = spurious_q;
    assign isr       = isr_q;

endmodule
